alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode-to-execute issue buffer directly upstream of the combinational ALU.
//  - Two-entry skid FIFO with valid/ready on both sides, so a stall from the EX/MEM side does not drop instructions.
//  - Resolves RAW hazards by forwarding from EX/MEM (combinational, head entry only) and by snooping WB writes into buffered entries.
//  - Selects immediate vs register for port_b and drives aluop/port_a/port_b on the ALU interface.
// PARAMETERS
//  WORD_W  32  datapath width; must equal width of word_t in cpu_types_pkg
//  REG_AW  5   register-number width; register 0 is hardwired zero
// PORTS
//  CLK          in   1       clock, rising edge
//  RST          in   1       reset; asynchronous assert, active-high
//  flush        in   1       synchronous pipeline kill (branch/jump redirect)
//  in_valid     in   1       decode presents an instruction
//  in_ready     out  1       buffer can accept this cycle
//  in_aluop     in   aluop_t ALU operation
//  in_rdat1     in   WORD_W  register-file read of rs
//  in_rdat2     in   WORD_W  register-file read of rt
//  in_imm       in   WORD_W  extended immediate
//  in_alusrc    in   1       1: port_b = imm, 0: port_b = rt value
//  in_rs/in_rt  in   REG_AW  source register numbers
//  in_wsel      in   REG_AW  destination register
//  in_regwen    in   1       instruction writes in_wsel
//  exm_regwen/exm_wsel/exm_wdat  in  1/REG_AW/WORD_W  EX/MEM forwarding source
//  wb_regwen/wb_wsel/wb_wdat     in  1/REG_AW/WORD_W  write-back bus (same cycle as RF write)
//  out_valid    out  1       head entry valid toward ALU/EX-MEM latch
//  out_ready    in   1       downstream consumes head this cycle
//  aluop        out  aluop_t to ALU
//  port_a/port_b out WORD_W  to ALU, forwarding applied
//  out_wsel/out_regwen out REG_AW/1  head destination, passed downstream
// BEHAVIOUR
//  - Occupancy count 0..2. in_ready = (count != 2), with no combinational path from out_ready.
//    At full, a same-cycle pop does not enable accept.
//  - accept = in_valid & in_ready; pop = out_valid & out_ready; out_valid = (count != 0).
//  - Latency: accept in cycle N -> out_valid in N+1 when empty. FIFO order is preserved. Simultaneous accept+pop keeps count.
//  - WB snoop:
//    - Every cycle, for each valid entry (and the entry being accepted): if wb_regwen & wb_wsel != 0 & wb_wsel == rs (rt), replace the stored rdat1 (rdat2) with wb_wdat.
//  - EX/MEM forward:
//    - Head only, combinational. If exm_regwen & exm_wsel != 0 & exm_wsel == head rs, port_a = exm_wdat; otherwise port_a = stored rdat1.
//    - Same rule for rt feeding the port_b register path.
//    - EX/MEM has priority over the stored/snooped value.
//  - port_b = head alusrc ? head imm : forwarded rt value. Register 0 is never forwarded or snooped.
//  - flush:
//    - Next edge: count = 0 and out_valid = 0. Flush wins over a same-cycle accept; the accepted data is discarded.
//    - in_ready is unaffected by flush in that cycle.
//  - Reset (RST high, any time, including mid-stall):
//    - count = 0, out_valid = 0, in_ready = 1.
//    - Storage is cleared, so aluop = ALU_SLL (4'b0000), port_a = port_b = 0, out_wsel = 0, out_regwen = 0.
//  - The outputs aluop/port_* are don't-care-stable when out_valid = 0, but must still equal the cleared values after reset.
//  - Pointers: 1-bit head/tail, wrapping 1 -> 0.
// STRUCTURE
//  - aluop_t, word_t and regbits_t come from cpu_types_pkg. Add issue_entry_t (packed aluop, rdat1, rdat2, imm, alusrc, rs, rt, wsel, regwen) to that package.
//  - One sub-module, fwd_unit: combinational compare/select for one operand, instanced twice (rs, rt).
//  - The ALU connection uses the existing alu_if from the testbench-facing side (at modport signals).
// TESTING
//  1. Reset mid-operation: count = 2, assert RST -> out_valid = 0, in_ready = 1, port_a = 0 immediately (async).
//  2. Back-to-back flow: 3 ADDs, out_ready = 1 constant -> one per cycle out, 1-cycle latency, order preserved.
//  3. Stall and full: out_ready = 0, offer 3 instrs -> in_ready drops after 2.
//     Raising out_ready while full with in_valid = 1 -> no accept that cycle.
//  4. Forward priority:
//     - head rs = 5, exm_wsel = 5, exm_wdat = 32'hAAAA_0001, wb_wsel = 5, wb_wdat = 32'h1 -> port_a = 32'hAAAA_0001.
//     - rs = 0 with exm_wsel = 0 -> port_a = stored value.
//  5. WB snoop while stalled: entry rt = 7 (alusrc = 0) buffered; wb writes r7 = 32'hDEAD_BEEF then goes idle -> port_b = 32'hDEAD_BEEF on release.
//  6. Flush with simultaneous accept at count = 1 -> next cycle count = 0, out_valid = 0, accepted instr never appears.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the issue-buffer entry layout.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned ISSUE_DEPTH = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_AW-1:0] regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    aluop_t   aluop;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    logic     alusrc;
    regbits_t rs;
    regbits_t rt;
    regbits_t wsel;
    logic     regwen;
  } issue_entry_t;

  // Replace an operand value when a register write targets its (non-zero) source register.
  function automatic word_t snoop_val(input logic wen, input regbits_t wsel, input word_t wdat,
                                      input regbits_t src, input word_t cur);
    return (wen && (wsel != '0) && (wsel == src)) ? wdat : cur;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Single-operand EX/MEM bypass: compare destination against source, select forwarded or stored value.
module fwd_unit
  import cpu_types_pkg::*;
(
  input  logic     exm_regwen,
  input  regbits_t exm_wsel,
  input  word_t    exm_wdat,
  input  regbits_t src,
  input  word_t    stored,
  output word_t    val
);

  // Register 0 is never bypassed.
  always_comb begin
    val = stored;
    if (exm_regwen && (exm_wsel != '0) && (exm_wsel == src)) begin
      val = exm_wdat;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue skid buffer in front of the ALU with WB snooping and EX/MEM forwarding.
module alu_issue_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  aluop_t   in_aluop,
  input  word_t    in_rdat1,
  input  word_t    in_rdat2,
  input  word_t    in_imm,
  input  logic     in_alusrc,
  input  regbits_t in_rs,
  input  regbits_t in_rt,
  input  regbits_t in_wsel,
  input  logic     in_regwen,
  input  logic     exm_regwen,
  input  regbits_t exm_wsel,
  input  word_t    exm_wdat,
  input  logic     wb_regwen,
  input  regbits_t wb_wsel,
  input  word_t    wb_wdat,
  output logic     out_valid,
  input  logic     out_ready,
  output aluop_t   aluop,
  output word_t    port_a,
  output word_t    port_b,
  output regbits_t out_wsel,
  output logic     out_regwen
);

  issue_entry_t mem_q [ISSUE_DEPTH];
  issue_entry_t mem_d [ISSUE_DEPTH];
  logic         head_q, head_d;
  logic         tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  logic                   accept;
  logic                   pop;
  logic [ISSUE_DEPTH-1:0] ent_valid;
  issue_entry_t           in_entry;
  issue_entry_t           head;
  word_t                  fwd_rt;

  // Buffer bookkeeping, WB snoop of stored and incoming operands, and flush.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    ent_valid[0] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'b0));
    ent_valid[1] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'b1));

    for (int unsigned i = 0; i < ISSUE_DEPTH; i++) begin
      if (ent_valid[i]) begin
        mem_d[i].rdat1 = snoop_val(wb_regwen, wb_wsel, wb_wdat, mem_q[i].rs, mem_q[i].rdat1);
        mem_d[i].rdat2 = snoop_val(wb_regwen, wb_wsel, wb_wdat, mem_q[i].rt, mem_q[i].rdat2);
      end
    end

    in_entry.aluop  = in_aluop;
    in_entry.rdat1  = snoop_val(wb_regwen, wb_wsel, wb_wdat, in_rs, in_rdat1);
    in_entry.rdat2  = snoop_val(wb_regwen, wb_wsel, wb_wdat, in_rt, in_rdat2);
    in_entry.imm    = in_imm;
    in_entry.alusrc = in_alusrc;
    in_entry.rs     = in_rs;
    in_entry.rt     = in_rt;
    in_entry.wsel   = in_wsel;
    in_entry.regwen = in_regwen;

    if (accept) begin
      mem_d[tail_q] = in_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + 2'(accept) - 2'(pop);

    // Redirect kills everything, including a same-cycle accept.
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end
  end

  // State and storage registers; reset clears storage so ALU-side outputs read as zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q   <= '{default: '0};
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head = mem_q[head_q];

  fwd_unit u_fwd_rs (
    .exm_regwen (exm_regwen),
    .exm_wsel   (exm_wsel),
    .exm_wdat   (exm_wdat),
    .src        (head.rs),
    .stored     (head.rdat1),
    .val        (port_a)
  );

  fwd_unit u_fwd_rt (
    .exm_regwen (exm_regwen),
    .exm_wsel   (exm_wsel),
    .exm_wdat   (exm_wdat),
    .src        (head.rt),
    .stored     (head.rdat2),
    .val        (fwd_rt)
  );

  // ALU-facing head view.
  always_comb begin
    aluop      = head.aluop;
    port_b     = head.alusrc ? head.imm : fwd_rt;
    out_wsel   = head.wsel;
    out_regwen = head.regwen;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage.
module tb_alu_issue_stage;
  import cpu_types_pkg::*;

  logic     CLK = 1'b0;
  logic     RST;
  logic     flush;
  logic     in_valid;
  logic     in_ready;
  aluop_t   in_aluop;
  word_t    in_rdat1, in_rdat2, in_imm;
  logic     in_alusrc;
  regbits_t in_rs, in_rt, in_wsel;
  logic     in_regwen;
  logic     exm_regwen;
  regbits_t exm_wsel;
  word_t    exm_wdat;
  logic     wb_regwen;
  regbits_t wb_wsel;
  word_t    wb_wdat;
  logic     out_valid;
  logic     out_ready;
  aluop_t   aluop;
  word_t    port_a, port_b;
  regbits_t out_wsel;
  logic     out_regwen;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_issue_stage dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rdat1(in_rdat1), .in_rdat2(in_rdat2), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_rs(in_rs), .in_rt(in_rt), .in_wsel(in_wsel), .in_regwen(in_regwen),
    .exm_regwen(exm_regwen), .exm_wsel(exm_wsel), .exm_wdat(exm_wdat),
    .wb_regwen(wb_regwen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .out_valid(out_valid), .out_ready(out_ready), .aluop(aluop),
    .port_a(port_a), .port_b(port_b), .out_wsel(out_wsel), .out_regwen(out_regwen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic instr(input aluop_t op, input regbits_t rs, input regbits_t rt,
                       input word_t r1, input word_t r2, input word_t imm,
                       input logic src, input regbits_t wsel);
    in_valid  = 1'b1;
    in_aluop  = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rdat1  = r1;
    in_rdat2  = r2;
    in_imm    = imm;
    in_alusrc = src;
    in_wsel   = wsel;
    in_regwen = 1'b1;
  endtask

  task automatic bus_idle();
    exm_regwen = 1'b0; exm_wsel = '0; exm_wdat = '0;
    wb_regwen  = 1'b0; wb_wsel  = '0; wb_wdat  = '0;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_aluop = ALU_SLL; in_rdat1 = '0; in_rdat2 = '0; in_imm = '0; in_alusrc = 1'b0;
    in_rs = '0; in_rt = '0; in_wsel = '0; in_regwen = 1'b0;
    bus_idle();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_aluop", 32'(aluop), 32'd0);
    chk("rst_port_a", port_a, 32'd0);
    chk("rst_port_b", port_b, 32'd0);
    chk("rst_out_regwen", 32'(out_regwen), 32'd0);
    tick();
    RST = 1'b0;

    // Back-to-back flow with downstream always ready.
    out_ready = 1'b1;
    instr(ALU_ADD, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 5'd3);
    chk("b2b_pre_valid", 32'(out_valid), 32'd0);
    tick();
    chk("b2b_a_valid", 32'(out_valid), 32'd1);
    chk("b2b_a_port_a", port_a, 32'd1);
    chk("b2b_a_port_b", port_b, 32'd2);
    chk("b2b_a_wsel", 32'(out_wsel), 32'd3);
    chk("b2b_a_aluop", 32'(aluop), 32'(ALU_ADD));
    instr(ALU_ADD, 5'd4, 5'd6, 32'd10, 32'd20, 32'd0, 1'b0, 5'd4);
    tick();
    chk("b2b_b_port_a", port_a, 32'd10);
    chk("b2b_b_port_b", port_b, 32'd20);
    chk("b2b_b_wsel", 32'(out_wsel), 32'd4);
    instr(ALU_ADD, 5'd8, 5'd9, 32'd7, 32'd99, 32'd100, 1'b1, 5'd5);
    tick();
    chk("b2b_c_port_a", port_a, 32'd7);
    chk("b2b_c_port_b_imm", port_b, 32'd100);
    chk("b2b_c_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain_valid", 32'(out_valid), 32'd0);

    // Stall and full.
    out_ready = 1'b0;
    instr(ALU_OR, 5'd1, 5'd2, 32'h11, 32'h0, 32'h0, 1'b0, 5'd1);
    tick();
    instr(ALU_OR, 5'd1, 5'd2, 32'h22, 32'h0, 32'h0, 1'b0, 5'd1);
    tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    instr(ALU_OR, 5'd1, 5'd2, 32'h33, 32'h0, 32'h0, 1'b0, 5'd1);
    tick();
    chk("full_hold_in_ready", 32'(in_ready), 32'd0);
    chk("full_hold_head", port_a, 32'h11);
    out_ready = 1'b1;
    chk("full_pop_no_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_pop_head", port_a, 32'h22);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("full_third_head", port_a, 32'h33);
    tick();
    chk("full_drain_valid", 32'(out_valid), 32'd0);

    // Forward priority and WB snoop of a buffered rs.
    out_ready = 1'b0;
    instr(ALU_ADD, 5'd5, 5'd0, 32'h1234, 32'h55, 32'h0, 1'b0, 5'd2);
    tick();
    in_valid = 1'b0;
    exm_regwen = 1'b1; exm_wsel = 5'd5; exm_wdat = 32'hAAAA_0001;
    wb_regwen  = 1'b1; wb_wsel  = 5'd5; wb_wdat  = 32'h1;
    #1;
    chk("fwd_exm_priority", port_a, 32'hAAAA_0001);
    chk("fwd_rt0_stored", port_b, 32'h55);
    exm_regwen = 1'b0;
    #1;
    chk("fwd_no_exm_stored", port_a, 32'h1234);
    tick();
    chk("snoop_rs_applied", port_a, 32'h1);
    bus_idle();
    out_ready = 1'b1;
    instr(ALU_ADD, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 5'd2);
    exm_regwen = 1'b1; exm_wsel = 5'd0; exm_wdat = 32'hFFFF;
    wb_regwen  = 1'b1; wb_wsel  = 5'd0; wb_wdat  = 32'hFFFF;
    tick();
    in_valid = 1'b0;
    chk("fwd_r0_never", port_a, 32'h77);
    tick();
    bus_idle();
    chk("fwd_drain_valid", 32'(out_valid), 32'd0);

    // WB snoop while stalled, then on release.
    out_ready = 1'b0;
    instr(ALU_SUB, 5'd3, 5'd7, 32'h3, 32'h0BAD, 32'h0, 1'b0, 5'd6);
    tick();
    in_valid = 1'b0;
    chk("snoop_pre_port_b", port_b, 32'h0BAD);
    wb_regwen = 1'b1; wb_wsel = 5'd7; wb_wdat = 32'hDEAD_BEEF;
    tick();
    bus_idle();
    tick();
    chk("snoop_port_a_untouched", port_a, 32'h3);
    out_ready = 1'b1;
    chk("snoop_release_port_b", port_b, 32'hDEAD_BEEF);
    tick();
    instr(ALU_SUB, 5'd3, 5'd7, 32'h3, 32'h0, 32'h0, 1'b0, 5'd6);
    wb_regwen = 1'b1; wb_wsel = 5'd7; wb_wdat = 32'hCAFE;
    tick();
    in_valid = 1'b0;
    bus_idle();
    chk("snoop_at_accept", port_b, 32'hCAFE);
    tick();

    // Flush with simultaneous accept at count = 1.
    out_ready = 1'b0;
    instr(ALU_AND, 5'd1, 5'd2, 32'h61, 32'h0, 32'h0, 1'b0, 5'd1);
    tick();
    instr(ALU_AND, 5'd1, 5'd2, 32'h62, 32'h0, 32'h0, 1'b0, 5'd1);
    flush = 1'b1;
    chk("flush_in_ready_same_cycle", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("flush_stays_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    instr(ALU_AND, 5'd1, 5'd2, 32'h63, 32'h0, 32'h0, 1'b0, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("flush_next_head", port_a, 32'h63);
    tick();
    chk("flush_drain_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stall with the buffer full.
    out_ready = 1'b0;
    instr(ALU_XOR, 5'd9, 5'd10, 32'h91, 32'h92, 32'h0, 1'b0, 5'd9);
    tick();
    instr(ALU_XOR, 5'd9, 5'd10, 32'h93, 32'h94, 32'h0, 1'b0, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("arst_pre_full", 32'(in_ready), 32'd0);
    chk("arst_pre_port_a", port_a, 32'h91);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_port_a", port_a, 32'd0);
    chk("arst_port_b", port_b, 32'd0);
    chk("arst_aluop", 32'(aluop), 32'd0);
    chk("arst_out_wsel", 32'(out_wsel), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("arst_after_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
